// File: rtl/wb_efuse_loader_if.sv
// Wishbone classic read channel between the eFuse loader (master) and the
// eFuse responder (slave).
interface wb_efuse_loader_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/wb_efuse_loader.sv
// Reads NUM_WORDS 32-bit eFuse words over Wishbone into a shadow register bank.
// Optional ack timeout enabled by defining EFUSE_LOADER_TIMEOUT_EN.
module wb_efuse_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter int          NUM_WORDS      = 4,
   parameter int          AUTO_LOAD      = 1,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   start_i,
   wb_efuse_loader_if.master      wbm,
   output logic [NUM_WORDS*32-1:0] shadow_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o
);

   localparam int                IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, ERR} state_t;

   if (NUM_WORDS < 1 || NUM_WORDS > 16) begin : g_bad_num_words
      $error("wb_efuse_loader: NUM_WORDS must be in 1..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_efuse_loader: TIMEOUT_CYCLES must be in 1..65535");
   end

   state_t                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic                     auto_arm_q;
   logic                     cyc_q;
   logic [31:0]              adr_q;
   logic [NUM_WORDS-1:0][31:0] shadow_q;
   logic                     busy_q;
   logic                     done_q;
`ifdef EFUSE_LOADER_TIMEOUT_EN
   logic                     err_q;
   logic [15:0]              tmo_cnt_q;
`endif

   always_ff @(posedge wb_clk_i) begin
      // NOTE: all state here is registered with <= so every branch sees pre-edge values.
      if (wb_rst_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         auto_arm_q <= 1'b1;
         cyc_q      <= 1'b0;
         adr_q      <= '0;
         shadow_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef EFUSE_LOADER_TIMEOUT_EN
         err_q      <= 1'b0;
         tmo_cnt_q  <= '0;
`endif
      end else begin
         auto_arm_q <= 1'b0;
         case (state_q)
            IDLE, DONE, ERR: begin
               // auto_arm_q is only high in the first cycle after reset release.
               if (start_i || (state_q == IDLE && auto_arm_q && AUTO_LOAD != 0)) begin
                  state_q <= REQ;
                  idx_q   <= '0;
                  cyc_q   <= 1'b1;
                  adr_q   <= BASE_ADDR;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
`ifdef EFUSE_LOADER_TIMEOUT_EN
                  err_q     <= 1'b0;
                  tmo_cnt_q <= '0;
`endif
               end
            end
            REQ: begin
               if (wbm.wbm_ack_i) begin
                  shadow_q[idx_q] <= wbm.wbm_dat_i;
                  cyc_q           <= 1'b0;
                  adr_q           <= '0;
                  if (idx_q == LAST_IDX) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= GAP;
                     idx_q   <= idx_q + IDX_W'(1);
                  end
               end
`ifdef EFUSE_LOADER_TIMEOUT_EN
               else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                  state_q <= ERR;
                  cyc_q   <= 1'b0;
                  adr_q   <= '0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
`endif
            end
            GAP: begin
               state_q <= REQ;
               cyc_q   <= 1'b1;
               adr_q   <= BASE_ADDR + (32'(idx_q) << 2);
`ifdef EFUSE_LOADER_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
            end
            default: begin
               state_q <= IDLE;
               cyc_q   <= 1'b0;
               adr_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wbm.wbm_cyc_o = cyc_q;
   assign wbm.wbm_stb_o = cyc_q;
   assign wbm.wbm_we_o  = 1'b0;
   assign wbm.wbm_sel_o = 4'hF;
   assign wbm.wbm_adr_o = adr_q;
   assign wbm.wbm_dat_o = 32'h0;

   assign shadow_o = shadow_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
`ifdef EFUSE_LOADER_TIMEOUT_EN
   assign error_o  = err_q;
`else
   assign error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_efuse_loader.sv
// Directed bench for wb_efuse_loader: auto load, wait states, restart,
// spurious acks, reset abort, and ack timeout (or indefinite wait).
module tb_wb_efuse_loader;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] shadow;
   logic         busy, done, error;

   int checks = 0;
   int errors = 0;

   // responder controls, written by the stimulus process only
   int          resp_ws       = 0;
   logic [31:0] resp_base     = 32'hA5A5_0000;
   logic        resp_inc      = 1'b1;
   logic        resp_force    = 1'b0;
   logic        resp_stall_en = 1'b0;
   int          resp_stall_k  = 0;
   logic [31:0] adr_log[$];

   wb_efuse_loader_if wb ();

   wb_efuse_loader #(
      .BASE_ADDR      (BASE),
      .NUM_WORDS      (4),
      .AUTO_LOAD      (1),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .start_i  (start),
      .wbm      (wb.master),
      .shadow_o (shadow),
      .busy_o   (busy),
      .done_o   (done),
      .error_o  (error)
   );

   always #5 clk = ~clk;

   // Responder: decides ack/data on each falling edge for the next rising edge.
   initial begin
      int cnt;
      int k;
      cnt = 0;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_dat_i = 32'h0;
      forever begin
         @(negedge clk);
         if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
            k = int'((wb.wbm_adr_o - BASE) >> 2);
            if (resp_stall_en && k == resp_stall_k) begin
               wb.wbm_ack_i = 1'b0;
               cnt = 0;
            end else if (cnt == resp_ws) begin
               wb.wbm_ack_i = 1'b1;
               wb.wbm_dat_i = resp_base + (resp_inc ? 32'(k) : 32'h0);
               adr_log.push_back(wb.wbm_adr_o);
               cnt = 0;
            end else begin
               wb.wbm_ack_i = 1'b0;
               cnt++;
            end
         end else begin
            wb.wbm_ack_i = resp_force;
            wb.wbm_dat_i = resp_force ? 32'hDEAD_BEEF : 32'h0;
            cnt = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Samples cyc each cycle until done_o rises; n counts cycles waited.
   task automatic wait_done(input int budget, output int n, output logic [63:0] pat);
      n = 0;
      pat = '0;
      while (done !== 1'b1 && n < budget) begin
         pat = {pat[62:0], wb.wbm_cyc_o};
         step();
         n++;
      end
   endtask

   task automatic wait_adr(input string tag, input logic [31:0] a, input int budget);
      int n;
      n = 0;
      while (wb.wbm_adr_o !== a && n < budget) begin
         step();
         n++;
      end
      chk(tag, wb.wbm_adr_o, a);
   endtask

   task automatic chk_adr_log(input string tag);
      chk({tag, " count"}, 128'(adr_log.size()), 128'd4);
      for (int i = 0; i < adr_log.size() && i < 4; i++)
         chk({tag, " entry"}, adr_log[i], BASE + 32'(4 * i));
   endtask

   function automatic logic [127:0] seq(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   initial begin
      int          n;
      logic [63:0] pat;
      logic [63:0] exp_pat;

      // ---------------- reset state ----------------
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) step();
      chk("rst cyc",    wb.wbm_cyc_o, 1'b0);
      chk("rst stb",    wb.wbm_stb_o, 1'b0);
      chk("rst adr",    wb.wbm_adr_o, 32'h0);
      chk("rst we",     wb.wbm_we_o,  1'b0);
      chk("rst sel",    wb.wbm_sel_o, 4'hF);
      chk("rst dat_o",  wb.wbm_dat_o, 32'h0);
      chk("rst shadow", shadow, 128'h0);
      chk("rst flags",  {busy, done, error}, 3'b000);

      // ---------------- auto load, zero wait ----------------
      resp_ws   = 0;
      resp_base = 32'hA5A5_0000;
      resp_inc  = 1'b1;
      adr_log.delete();
      rst = 1'b0;
      step();
      chk("auto req cyc", {wb.wbm_cyc_o, wb.wbm_stb_o}, 2'b11);
      chk("auto req adr", wb.wbm_adr_o, 32'h3000_0000);
      chk("auto req flags", {busy, done, error}, 3'b100);
      chk("auto req we/sel", {wb.wbm_we_o, wb.wbm_sel_o}, 5'b0_1111);
      wait_done(50, n, pat);
      chk("auto load cycles", n, 7);
      chk("auto cyc pattern", pat, 64'b1010101);
      chk("auto shadow", shadow, 128'hA5A5_0003_A5A5_0002_A5A5_0001_A5A5_0000);
      chk("auto done flags", {busy, done, error, wb.wbm_cyc_o}, 4'b0100);
      chk_adr_log("auto adr log");

      // ---------------- three wait states per word ----------------
      resp_ws   = 3;
      resp_base = 32'hC0DE_0000;
      adr_log.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ws done cleared", done, 1'b0);
      wait_done(100, n, pat);
      exp_pat = '0;
      for (int w = 0; w < 4; w++) begin
         exp_pat = {exp_pat[59:0], 4'b1111};
         if (w < 3) exp_pat = {exp_pat[62:0], 1'b0};
      end
      chk("ws load cycles", n, 19);
      chk("ws cyc pattern", pat, exp_pat);
      chk("ws shadow", shadow, seq(32'hC0DE_0000));
      chk_adr_log("ws adr log");

      // ---------------- start held through REQ/GAP is ignored ----------------
      resp_ws   = 0;
      resp_base = 32'h1234_5678;
      resp_inc  = 1'b0;
      start = 1'b1;
      step();
      chk("restart flags", {busy, done}, 2'b10);
      chk("restart adr0", wb.wbm_adr_o, 32'h3000_0000);
      step();
      chk("restart gap cyc", {wb.wbm_cyc_o, busy}, 2'b01);
      step();
      chk("start ignored adr1", wb.wbm_adr_o, 32'h3000_0004);
      start = 1'b0;
      wait_done(50, n, pat);
      chk("restart remaining cycles", n, 5);
      chk("restart shadow", shadow, {4{32'h1234_5678}});

      // ---------------- spurious ack in DONE ----------------
      resp_force = 1'b1;
      step();
      step();
      chk("spur done shadow", shadow, {4{32'h1234_5678}});
      chk("spur done state", {busy, done, wb.wbm_cyc_o}, 3'b010);
      resp_force = 1'b0;
      step();

      // ---------------- spurious ack in GAP ----------------
      resp_base = 32'hA5A5_0000;
      resp_inc  = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      resp_force = 1'b1;
      step();
      chk("spur gap state", {wb.wbm_cyc_o, busy}, 2'b01);
      resp_force = 1'b0;
      step();
      chk("spur gap next adr", wb.wbm_adr_o, 32'h3000_0004);
      wait_done(50, n, pat);
      chk("spur gap cycles", n, 5);
      chk("spur gap shadow", shadow, seq(32'hA5A5_0000));

      // ---------------- reset while waiting on word 1 ----------------
      resp_ws   = 3;
      resp_base = 32'h5555_0000;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_adr("rstmid reach w1", 32'h3000_0004, 20);
      rst = 1'b1;
      step();
      chk("rstmid cyc/stb", {wb.wbm_cyc_o, wb.wbm_stb_o}, 2'b00);
      chk("rstmid adr", wb.wbm_adr_o, 32'h0);
      chk("rstmid shadow", shadow, 128'h0);
      chk("rstmid flags", {busy, done, error}, 3'b000);
      step();
      rst = 1'b0;
      adr_log.delete();
      step();
      chk("rstmid reload cyc", wb.wbm_cyc_o, 1'b1);
      chk("rstmid reload adr", wb.wbm_adr_o, 32'h3000_0000);
      wait_done(100, n, pat);
      chk("rstmid reload cycles", n, 19);
      chk("rstmid reload shadow", shadow, seq(32'h5555_0000));
      chk_adr_log("rstmid adr log");

      // ---------------- no ack on word 2 ----------------
      resp_ws       = 0;
      resp_base     = 32'h7777_0000;
      resp_stall_en = 1'b1;
      resp_stall_k  = 2;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_adr("stall reach w2", 32'h3000_0008, 20);
`ifdef EFUSE_LOADER_TIMEOUT_EN
      n = 0;
      while (error !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("tmo cycles", n, 8);
      chk("tmo flags", {busy, done, error}, 3'b001);
      chk("tmo cyc", wb.wbm_cyc_o, 1'b0);
      chk("tmo shadow", shadow,
          {32'h5555_0003, 32'h5555_0002, 32'h7777_0001, 32'h7777_0000});
      resp_stall_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("tmo restart flags", {busy, done, error}, 3'b100);
      wait_done(50, n, pat);
      chk("tmo reload cycles", n, 7);
      chk("tmo reload shadow", shadow, seq(32'h7777_0000));
`else
      repeat (300) step();
      chk("stall still waiting", {wb.wbm_cyc_o, busy, done, error}, 4'b1100);
      chk("stall adr", wb.wbm_adr_o, 32'h3000_0008);
      chk("stall shadow", shadow,
          {32'h5555_0003, 32'h5555_0002, 32'h7777_0001, 32'h7777_0000});
      resp_stall_en = 1'b0;
      wait_done(50, n, pat);
      chk("stall released done", {busy, done, error}, 3'b010);
      chk("stall released shadow", shadow, seq(32'h7777_0000));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
